jk_target_tracker: RTL and testbench

- Register-transfer block that drives a bank of JK flip-flops toward a requested target value, one count step per clock.
- Each cell gets its J/K inputs from excitation logic, the inverse of the JK characteristic equation: the desired next state maps back to the required J/K values.
- Sits beside the standalone JK flip-flop work as its driving side; verification uses the exposed J/K vectors.
- Targets are delivered over a valid/ready handshake.

---
 rtl/jktt_pkg.sv | 14 +
 rtl/jk_target_tracker_ffjk_cell.sv | 18 +
 rtl/jk_target_tracker.sv | 101 ++++++++++
 tb/tb_jk_target_tracker.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/jktt_pkg.sv
// Shared definitions for jk_target_tracker: FSM state codes and the JK excitation function.
package jktt_pkg;

    localparam logic [1:0] IDLE  = 2'b00;
    localparam logic [1:0] TRACK = 2'b01;
    localparam logic [1:0] DONE  = 2'b10;

    // Inverse of the JK characteristic equation; the don't-care entries are resolved
    // to 0, so the toggle code J=K=1 never appears.
    function automatic logic [1:0] jk_excite(input logic q_bit, input logic next_bit);
        return {next_bit & ~q_bit, q_bit & ~next_bit};
    endfunction

endpackage

// File: rtl/jk_target_tracker_ffjk_cell.sv
// Single JK flip-flop, rising-edge clocked, asynchronous active-low reset to 0.
module ffjk_cell (
    input  logic clk,
    input  logic reset_async,
    input  logic j,
    input  logic k,
    output logic q
);

    always_ff @(posedge clk or negedge reset_async) begin
        if (!reset_async) begin
            q <= 1'b0;
        end else begin
            q <= (j & ~q) | (~k & q);
        end
    end

endmodule

// File: rtl/jk_target_tracker.sv
// Steps a bank of JK flip-flops one count per clock toward a handshaked target value.
// Optional macro JKTT_SHORTEST_PATH_EN selects the shorter modular direction (ties go up).
module jk_target_tracker
    import jktt_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset_async,
    input  logic             tgt_valid,
    input  logic [WIDTH-1:0] tgt_data,
    output logic             tgt_ready,
    output logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             done,
    output logic             dir,
    output logic [WIDTH-1:0] j_vec,
    output logic [WIDTH-1:0] k_vec
);

    logic [1:0]       state;
    logic [WIDTH-1:0] target;
    logic             dir_r;
    logic [WIDTH-1:0] next_q;
    logic [WIDTH-1:0] j_int;
    logic [WIDTH-1:0] k_int;
    logic             up_sel;

`ifdef JKTT_SHORTEST_PATH_EN
    localparam logic [WIDTH-1:0] HALF = {1'b1, {(WIDTH-1){1'b0}}};
    logic [WIDTH-1:0] diff;

    always_comb begin
        diff   = tgt_data - q;
        up_sel = (diff <= HALF);
    end
`else
    always_comb begin
        up_sel = (tgt_data > q);
    end
`endif

    always_comb begin
        next_q = dir_r ? (q + WIDTH'(1)) : (q - WIDTH'(1));
        j_int  = '0;
        k_int  = '0;
        if (state == TRACK) begin
            for (int i = 0; i < WIDTH; i++) begin
                {j_int[i], k_int[i]} = jk_excite(q[i], next_q[i]);
            end
        end
    end

    // The counter state lives only in the JK cells; q is never loaded directly.
    for (genvar g = 0; g < WIDTH; g++) begin : g_cell
        ffjk_cell u_cell (
            .clk        (clk),
            .reset_async(reset_async),
            .j          (j_int[g]),
            .k          (k_int[g]),
            .q          (q[g])
        );
    end

    always_ff @(posedge clk or negedge reset_async) begin
        if (!reset_async) begin
            state  <= IDLE;
            target <= '0;
            dir_r  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (tgt_valid) begin
                        target <= tgt_data;
                        if (tgt_data == q) begin
                            state <= DONE;
                        end else begin
                            state <= TRACK;
                            dir_r <= up_sel;
                        end
                    end
                end
                TRACK: begin
                    if (next_q == target) begin
                        state <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign tgt_ready = (state == IDLE);
    assign busy      = (state == TRACK);
    assign done      = (state == DONE);
    assign dir       = dir_r;
    assign j_vec     = j_int;
    assign k_vec     = k_int;

endmodule

// File: tb/tb_jk_target_tracker.sv
// Self-checking bench for jk_target_tracker: directed scenarios plus random targets vs a step model.
module tb_jk_target_tracker;

    localparam int W = 4;
    localparam int M = 1 << W;

    logic         clk = 1'b0;
    logic         reset_async;
    logic         tgt_valid;
    logic [W-1:0] tgt_data;
    logic         tgt_ready;
    logic [W-1:0] q;
    logic         busy;
    logic         done;
    logic         dir;
    logic [W-1:0] j_vec;
    logic [W-1:0] k_vec;

    int checks = 0;
    int errors = 0;
    int qm     = 0;

    jk_target_tracker #(.WIDTH(W)) dut (
        .clk        (clk),
        .reset_async(reset_async),
        .tgt_valid  (tgt_valid),
        .tgt_data   (tgt_data),
        .tgt_ready  (tgt_ready),
        .q          (q),
        .busy       (busy),
        .done       (done),
        .dir        (dir),
        .j_vec      (j_vec),
        .k_vec      (k_vec)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Number of steps and direction from the rules: plain distance, or shortest modular path.
    task automatic plan(input int qv, input int t, output int d, output bit up);
        int diff;
        diff = (t - qv + M) % M;
`ifdef JKTT_SHORTEST_PATH_EN
        up = (diff <= M / 2);
        d  = up ? diff : (M - diff);
`else
        up = (t > qv);
        d  = up ? (t - qv) : (qv - t);
`endif
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_target(input int t, input bit hold);
        int d;
        bit up;
        int nxt;
        int waited;
        waited = 0;
        while (tgt_ready !== 1'b1 && waited < 50) begin
            tick();
            waited++;
        end
        check("ready_before_accept", tgt_ready, 1'b1);
        plan(qm, t, d, up);
        tgt_valid = 1'b1;
        tgt_data  = W'(t);
        tick();
        if (hold) begin
            tgt_data = '0;
        end else begin
            tgt_valid = 1'b0;
        end
        for (int s = 0; s < d; s++) begin
            nxt = up ? (qm + 1) % M : (qm + M - 1) % M;
            check("busy_track", busy, 1'b1);
            check("done_track", done, 1'b0);
            check("ready_track", tgt_ready, 1'b0);
            check("dir_track", dir, up);
            check("q_before_step", q, qm);
            check("j_vec", j_vec, nxt & ~qm & (M - 1));
            check("k_vec", k_vec, qm & ~nxt & (M - 1));
            tick();
            qm = nxt;
            check("q_after_step", q, qm);
        end
        check("q_at_done", q, t);
        check("done_pulse", done, 1'b1);
        check("busy_in_done", busy, 1'b0);
        check("ready_in_done", tgt_ready, 1'b0);
        check("jk_zero_in_done", {j_vec, k_vec}, '0);
        tick();
        check("done_cleared", done, 1'b0);
        check("ready_after_done", tgt_ready, 1'b1);
        check("q_held", q, t);
    endtask

    initial begin
        bit up;
        int d;
        reset_async = 1'b0;
        tgt_valid   = 1'b0;
        tgt_data    = '0;
        #1;
        check("rst_q", q, 0);
        check("rst_ready", tgt_ready, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_dir", dir, 1'b0);
        check("rst_jk", {j_vec, k_vec}, '0);
        #11 reset_async = 1'b1;
        tick();

        run_target(5, 1'b0);
        run_target(2, 1'b0);
        run_target(2, 1'b0);

        // Mid-operation reset between edges: back to 0 at once, no resume, no done.
        run_target(0, 1'b0);
        tgt_valid = 1'b1;
        tgt_data  = W'(9);
        tick();
        tgt_valid = 1'b0;
        plan(0, 9, d, up);
        for (int s = 0; s < 3; s++) tick();
        check("mid_q_before_rst", q, 3);
        #2 reset_async = 1'b0;
        #1;
        check("mid_rst_q", q, 0);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_ready", tgt_ready, 1'b1);
        check("mid_rst_done", done, 1'b0);
        #3 reset_async = 1'b1;
        qm = 0;
        for (int s = 0; s < 4; s++) begin
            tick();
            check("post_rst_q", q, 0);
            check("post_rst_done", done, 1'b0);
            check("post_rst_ready", tgt_ready, 1'b1);
        end

        // Target offered continuously during TRACK is not taken until IDLE.
        run_target(7, 1'b1);
        run_target(0, 1'b0);

        run_target(1, 1'b0);
        run_target(14, 1'b0);

        for (int n = 0; n < 30; n++) begin
            int t;
            bit hold;
            t    = $urandom_range(0, M - 1);
            hold = ($urandom_range(0, 3) == 0);
            run_target(t, hold);
            if (hold) run_target(0, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
